inv_mapper_engine: RTL

INV_MAPPER_ENGINE -- requirements
Module: inv_mapper_engine

---
 rtl/mapper_pkg.sv | 29 ++
 rtl/inv_mapper.sv | 18 +
 rtl/inv_mapper_engine.sv | 66 ++++++
 3 files changed

// File: rtl/mapper_pkg.sv
// Shared slice-mapper definitions: default geometry, FSM state encoding and
// the lane index helpers used by both the forward and the inverse mapper.
package mapper_pkg;

    localparam int N_DEF = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Flat bit position of coordinate (a,b); the (N+1)/2 offset re-centres
    // the slice so that coordinate (0,0) lands on the middle bit.
    function automatic int idx(input int a, input int b, input int n);
        int h;
        h = (n + 1) / 2;
        return ((b + n - h) % n) * n + ((a + n - h) % n);
    endfunction

    // Source bit feeding result bit idx(i,j) in one inverse step.
    function automatic int inv_src_idx(input int i, input int j, input int n);
        return idx(j, (2 * i + 3 * j) % n, n);
    endfunction

    // Destination bit written by source bit idx(i,j) in one forward step.
    function automatic int fwd_dst_idx(input int i, input int j, input int n);
        return idx(j, (2 * i + 3 * j) % n, n);
    endfunction

endpackage

// File: rtl/inv_mapper.sv
// One combinational inverse slice-mapping step: pure bit permutation.
module inv_mapper
    import mapper_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N*N-1:0] src,
    output logic [N*N-1:0] dst
);

    // Every result bit is a wire from exactly one source bit.
    for (genvar i = 0; i < N; i++) begin : g_i
        for (genvar j = 0; j < N; j++) begin : g_j
            assign dst[idx(i, j, N)] = src[inv_src_idx(i, j, N)];
        end
    end

endmodule

// File: rtl/inv_mapper_engine.sv
// Iterative inverse slice mapper: accepts a slice and a round count R,
// applies the inverse step R times (one per cycle), then holds the result
// until the consumer takes it.
module inv_mapper_engine
    import mapper_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N*N-1:0] in_data,
    input  logic [RW-1:0] in_rounds,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N*N-1:0] out_data,
    output logic          busy
);

    logic [1:0]    state;
    logic [RW-1:0] cnt;
    logic [N*N-1:0] slice;
    logic [N*N-1:0] step;

    inv_mapper #(.N(N)) u_inv (
        .src(slice),
        .dst(step)
    );

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_RUN);
    assign out_data  = slice;

    // Control and datapath; DONE is entered on the edge that takes cnt from
    // 1 to 0, so the counter never wraps even at the maximum round count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            slice <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        slice <= in_data;
                        cnt   <= in_rounds;
                        state <= (in_rounds == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    slice <= step;
                    cnt   <= cnt - 1'b1;
                    if (cnt == RW'(1)) state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
